// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline memory request at a time into word-wide
// accesses on a single-port data memory. Sub-word stores are done as
// read-modify-write. Misaligned or reserved-size requests complete with an error
// and never touch memory.
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic        store_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        error_q;

  logic        accept;
  logic        req_misaligned;
  logic [4:0]  lane_shift;
  logic [31:0] lane_word;
  logic [31:0] lane_mask;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept = (state_q == StIdle) && req_valid;

  // Classify the incoming request: misaligned halves/words and the reserved size.
  always_comb begin
    req_misaligned = 1'b0;
    unique case (req_size)
      SizeByte: req_misaligned = 1'b0;
      SizeHalf: req_misaligned = req_addr[0];
      SizeWord: req_misaligned = |req_addr[1:0];
      default:  req_misaligned = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: errors skip memory, word stores skip the read, sub-word stores do RMW.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_misaligned) begin
            state_d = StResp;
          end else if (req_store && (req_size == SizeWord)) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = store_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request fields latched on accept; memory word captured at the end of READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      store_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        store_q  <= req_store;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        error_q  <= req_misaligned;
      end
      if (state_q == StRead) begin
        word_q <= mem_read_data;
      end
    end
  end

  // Bit position of the addressed lane inside the word; big-endian puts offset 0 at the top.
  always_comb begin
    lane_shift = 5'd0;
    case (size_q)
      SizeByte: lane_shift = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
      SizeHalf: lane_shift = BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
      default:  lane_shift = 5'd0;
    endcase
  end

  assign lane_word = word_q >> lane_shift;

  // Load extraction: right-align the lane, then sign- or zero-extend.
  always_comb begin
    load_data = word_q;
    case (size_q)
      SizeByte: load_data = signed_q ? {{24{lane_word[7]}}, lane_word[7:0]}
                                     : {24'h0, lane_word[7:0]};
      SizeHalf: load_data = signed_q ? {{16{lane_word[15]}}, lane_word[15:0]}
                                     : {16'h0, lane_word[15:0]};
      default:  load_data = word_q;
    endcase
  end

  // Store merge: replace only the addressed lane of the captured word.
  always_comb begin
    lane_mask  = 32'h0;
    store_word = wdata_q;
    case (size_q)
      SizeByte: begin
        lane_mask  = 32'h0000_00ff << lane_shift;
        store_word = (word_q & ~lane_mask) | ({24'h0, wdata_q[7:0]} << lane_shift);
      end
      SizeHalf: begin
        lane_mask  = 32'h0000_ffff << lane_shift;
        store_word = (word_q & ~lane_mask) | ({16'h0, wdata_q[15:0]} << lane_shift);
      end
      default: begin
        lane_mask  = 32'hffff_ffff;
        store_word = wdata_q;
      end
    endcase
  end

  // Outputs decode straight from state so an async reset drops the write strobe at once.
  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_error       = 1'b0;
    resp_rdata       = 32'h0;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'h0;
    mem_addr         = {addr_q[31:2], 2'b00};
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
      StRead:  ;
      StWrite: begin
        mem_write_enable = 1'b1;
        mem_write_data   = store_word;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_error = error_q;
        if (!error_q && !store_q) begin
          resp_rdata = load_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (BIG_ENDIAN=1) with a small word memory model.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_data;

  int errors = 0;
  int checks = 0;

  load_store_unit #(
    .BIG_ENDIAN(1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_error      (resp_error),
    .resp_rdata      (resp_rdata),
    .mem_addr        (mem_addr),
    .mem_write_enable(mem_write_enable),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single writer for the memory: bench preloads and DUT writes.
  always @(posedge clock) begin
    if (poke_en) begin
      mem[poke_idx] <= poke_data;
    end else if (mem_write_enable) begin
      mem[mem_addr[7:2]] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_addr[7:2]];

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic        wr;
    logic [31:0] wword;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clock);
    poke_en   = 1'b1;
    poke_idx  = idx;
    poke_data = data;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h0);
    check({tag, " resp_error"}, {31'h0, resp_error}, 32'h0);
    check({tag, " resp_rdata"}, resp_rdata, 32'h0);
    check({tag, " mem_addr"}, mem_addr, 32'h0);
    check({tag, " mem_we"}, {31'h0, mem_write_enable}, 32'h0);
    check({tag, " mem_wdata"}, mem_write_data, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          nwr;
    logic [31:0] wseen;
    logic        leak;
    logic [31:0] rd;
    logic        er;
    logic        rdy;
    string       t;
    t = $sformatf("v%0d", idx);
    poke(v.addr[7:2], v.init);
    @(negedge clock);
    rdy        = req_ready;
    req_valid  = 1'b1;
    req_store  = v.store;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clock);
    lat = 99; nwr = 0; wseen = 32'h0; leak = 1'b0; rd = 32'h0; er = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) begin
        req_valid = 1'b0;
        check({t, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
      end
      if (mem_write_enable) begin
        nwr++;
        wseen = mem_write_data;
      end else if (mem_write_data != 32'h0) begin
        leak = 1'b1;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        er  = resp_error;
        break;
      end
    end
    check({t, " ready"}, {31'h0, rdy}, 32'h1);
    check({t, " latency"}, 32'(lat), 32'(v.lat));
    check({t, " error"}, {31'h0, er}, {31'h0, v.err});
    check({t, " rdata"}, rd, v.rdata);
    check({t, " writes"}, 32'(nwr), v.wr ? 32'd1 : 32'd0);
    if (v.wr) check({t, " wdata"}, wseen, v.wword);
    check({t, " wdata_idle"}, {31'h0, leak}, 32'h0);
    check({t, " mem"}, mem[v.addr[7:2]], v.wr ? v.wword : v.init);
  endtask

  vec_t vecs [16];

  initial begin
    logic [7:0]  rdy_bits;
    logic [7:0]  rsp_bits;
    logic [7:0]  we_bits;
    logic [31:0] b2b_rdata;
    int          rsp_cnt;

    //         store size   sgn   addr   wdata         init          err   rdata         lat wr    wword
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h11223344, 1'b0, 32'h00000022, 2, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h11223344, 1'b0, 32'h00000044, 2, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h80FF7F01, 1'b0, 32'hFFFF80FF, 2, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h80FF7F01, 1'b0, 32'h000080FF, 2, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'h80FF7F01, 1'b0, 32'h0000007F, 2, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'h80FF7F01, 1'b0, 32'hFFFFFF80, 2, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h80FF7F01, 1'b0, 32'h00007F01, 2, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        32'h80FF7F01, 1'b0, 32'h80FF7F01, 2, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h000000EE, 32'hAABBCCDD, 1'b0, 32'h0,        3, 1'b1, 32'hAAEECCDD};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 32'hAABBCCDD, 1'b0, 32'h0,        3, 1'b1, 32'hAABB1234};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF5678, 32'hAABBCCDD, 1'b0, 32'h0,        3, 1'b1, 32'h5678CCDD};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h23, 32'hABABAB55, 32'hAABBCCDD, 1'b0, 32'h0,        3, 1'b1, 32'hAABBCC55};
    vecs[12] = '{1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'h0,        2, 1'b1, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 32'h0BADF00D, 1'b1, 32'h0,        1, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 2'b01, 1'b1, 32'h03, 32'h0,        32'h12345678, 1'b1, 32'h0,        1, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 2'b11, 1'b0, 32'h08, 32'h0,        32'h55AA55AA, 1'b1, 32'h0,        1, 1'b0, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; poke_en = 1'b0; poke_idx = 6'h0; poke_data = 32'h0;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("idle");

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Async reset during the WRITE cycle of a word store.
    poke(6'h10, 32'h01020304);
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("abort we_before", {31'h0, mem_write_enable}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("abort we_async", {31'h0, mem_write_enable}, 32'h0);
    check("abort wdata_async", mem_write_data, 32'h0);
    @(negedge clock);
    check_reset_outputs("abort");
    reset = 1'b0;
    rsp_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (resp_valid) rsp_cnt++;
    end
    check("abort no_resp", 32'(rsp_cnt), 32'h0);
    check("abort mem", mem[16], 32'h01020304);

    // req_valid held high across a load and then a store.
    poke(6'h04, 32'h80FF7F01);
    poke(6'h0C, 32'h00000000);
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h0;
    @(posedge clock);
    rdy_bits = 8'h0; rsp_bits = 8'h0; we_bits = 8'h0; b2b_rdata = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      rdy_bits[c-1] = req_ready;
      rsp_bits[c-1] = resp_valid;
      we_bits[c-1]  = mem_write_enable;
      if (c == 2) b2b_rdata = resp_rdata;
      if (c == 1) begin
        req_store = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h11111111;
      end
      if (c == 4) req_valid = 1'b0;
    end
    check("b2b ready", {24'h0, rdy_bits}, 32'h000000E4);
    check("b2b resp", {24'h0, rsp_bits}, 32'h00000012);
    check("b2b we", {24'h0, we_bits}, 32'h00000008);
    check("b2b rdata", b2b_rdata, 32'h0000007F);
    check("b2b mem", mem[12], 32'h11111111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1; 1 = byte offset 0 maps to bits 31:24, 0 = byte offset 0 maps to bits 7:0.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  pipeline memory request present.
REQ-006 req_ready  output  1  unit idle, request accepted this cycle if req_valid.
REQ-007 req_store  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 req_signed  input  1  sign-extend sub-word load (lb/lh) when 1, zero-extend (lbu/lhu) when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned for sub-word stores.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_error  output  1  misaligned or reserved-size request; valid with resp_valid.
REQ-014 resp_rdata  output  32  extended load result; valid with resp_valid.
REQ-015 mem_addr  output  32  word address to data memory, bits 1:0 always 00.
REQ-016 mem_write_enable  output  1  word write strobe to data memory.
REQ-017 mem_write_data  output  32  full word to write.
REQ-018 mem_read_data  input  32  combinational read word from data memory at mem_addr.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On req_valid in IDLE, the unit SHALL latch store, size, signed, addr and wdata; mem_addr SHALL be {latched addr[31:2],2'b00} in every state.
REQ-021 Misalignment SHALL be: half with addr[0]=1, word with addr[1:0]!=00, or size 11; such requests SHALL go IDLE->RESP with resp_error=1, resp_rdata=0, and no write.
REQ-022 Load: IDLE->READ->RESP->IDLE; in READ, mem_read_data SHALL be captured at the clock edge.
REQ-023 Word store: IDLE->WRITE->RESP->IDLE; mem_write_enable=1 for exactly the WRITE cycle with mem_write_data = latched wdata.
REQ-024 Sub-word store (read-modify-write): IDLE->READ->WRITE->RESP->IDLE; the WRITE word SHALL equal the captured word with only the addressed byte/half replaced by wdata[7:0]/wdata[15:0].
REQ-025 Lane selection SHALL follow BIG_ENDIAN; for BIG_ENDIAN=1, half offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-026 Load extraction SHALL right-align the addressed lane and sign- or zero-extend to 32 bits per latched signed; word loads SHALL ignore signed.
REQ-027 resp_valid SHALL be 1 only in RESP; there is no response backpressure.
REQ-028 Latency from accept edge to resp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-029 mem_write_enable SHALL be 0 in every state except WRITE; mem_write_data SHALL be 0 outside WRITE.
REQ-030 Requests presented while req_ready=0 SHALL be ignored and not queued; back-to-back requests SHALL be accepted in the IDLE cycle following RESP.

Reset
REQ-031 Reset SHALL force IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_addr=0, mem_write_enable=0, mem_write_data=0, and clear all latched fields.
REQ-032 Reset asserted mid-operation, including in WRITE, SHALL deassert mem_write_enable immediately without waiting for a clock edge; the aborted request SHALL produce no response.

Verification
REQ-033 Memory word 0x10 = 0x11223344, BIG_ENDIAN=1, lb at 0x11 -> resp_rdata 0x00000022 two cycles after accept; lb at 0x13 -> 0x00000044.
REQ-034 Memory word 0x10 = 0x80FF7F01, lh at 0x10 -> 0xFFFF80FF; lhu at 0x10 -> 0x000080FF; lbu at 0x12 -> 0x0000007F.
REQ-035 Memory word 0x20 = 0xAABBCCDD, sb 0x000000EE at 0x21 -> single WRITE cycle with 0xAAEECCDD, resp_valid 3 cycles after accept; sh 0x1234 at 0x22 -> 0xAABB1234.
REQ-036 sw at 0x06 -> resp_error=1 one cycle after accept, mem_write_enable never high; lh at 0x03 -> error, resp_rdata 0.
REQ-037 Reset asserted asynchronously during WRITE of sw 0xDEADBEEF at 0x40 -> mem_write_enable drops before the next edge, no resp_valid, memory word 0x40 unchanged.
REQ-038 req_valid held high across a load then a store -> second request accepted only in the IDLE cycle after the first RESP, with no dropped or duplicated writes.
